// File: rtl/fp_convert_seq.sv
// fp_convert_seq
// Converts a 12-bit two's-complement sample into a small sign/exponent/
// significand float (1/3/4) by iterative normalisation, one shift per cycle.
// Rounding is delegated to an external combinational unit that sees the
// normalised exponent, the top four significand bits and the round bit.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only in IDLE
//   d_in     12-bit two's-complement sample
//   busy     high whenever the FSM is not in IDLE
//   done     one-cycle pulse; s/e/f valid from this cycle on
//   s, e, f  registered result (sign, 3-bit exponent, 4-bit significand)
//   rnd_exp  exponent to the rounding unit
//   rnd_sig  significand to the rounding unit
//   rnd_bit  round bit to the rounding unit
//   rnd_e    rounded exponent back from the rounding unit
//   rnd_f    rounded significand back from the rounding unit
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sample captured on accept
// LOAD  | magnitude formed from the captured sample, exponent preset to 7
// NORM  | shift left until mag[10] is set or the exponent reaches 0
// ROUND | capture the rounding unit's result into s/e/f
// DONE  | done pulse, back to IDLE

module fp_convert_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] d_in,
  output logic        busy,
  output logic        done,
  output logic        s,
  output logic [2:0]  e,
  output logic [3:0]  f,
  output logic [2:0]  rnd_exp,
  output logic [3:0]  rnd_sig,
  output logic        rnd_bit,
  input  logic [2:0]  rnd_e,
  input  logic [3:0]  rnd_f
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] NORM  = 3'd2;
  localparam logic [2:0] ROUND = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [11:0] d_reg;
  logic        sign_reg;
  logic [10:0] mag;
  logic [2:0]  exp_cnt;
  logic [11:0] d_neg;
  logic [10:0] mag_load;

  // -0x800 does not fit in 11 bits, so it clamps to the largest magnitude.
  always_comb begin
    d_neg = ~d_reg + 12'd1;
    if (!d_reg[11])
      mag_load = d_reg[10:0];
    else if (d_reg == 12'h800)
      mag_load = 11'h7FF;
    else
      mag_load = d_neg[10:0];
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rnd_exp = exp_cnt;
  assign rnd_sig = mag[10:7];
  assign rnd_bit = mag[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      d_reg    <= 12'd0;
      sign_reg <= 1'b0;
      mag      <= 11'd0;
      exp_cnt  <= 3'd0;
      s        <= 1'b0;
      e        <= 3'd0;
      f        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_reg    <= d_in;
            sign_reg <= d_in[11];
            state    <= LOAD;
          end
        end
        LOAD: begin
          mag     <= mag_load;
          exp_cnt <= 3'd7;
          state   <= NORM;
        end
        NORM: begin
          if (mag[10] || (exp_cnt == 3'd0)) begin
            state <= ROUND;
          end else begin
            mag     <= {mag[9:0], 1'b0};
            exp_cnt <= exp_cnt - 3'd1;
          end
        end
        ROUND: begin
          s     <= sign_reg;
          e     <= rnd_e;
          f     <= rnd_f;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
module tb_fp_convert_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] d_in;
  logic        busy;
  logic        done;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic [2:0]  rnd_exp;
  logic [3:0]  rnd_sig;
  logic        rnd_bit;
  logic [2:0]  rnd_e;
  logic [3:0]  rnd_f;

  fp_convert_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d_in(d_in),
    .busy(busy), .done(done), .s(s), .e(e), .f(f),
    .rnd_exp(rnd_exp), .rnd_sig(rnd_sig), .rnd_bit(rnd_bit),
    .rnd_e(rnd_e), .rnd_f(rnd_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External rounding unit: round-half-up on the 4-bit significand,
  // carry into the exponent, saturate at the top exponent.
  always_comb begin
    rnd_e = rnd_exp;
    rnd_f = rnd_sig;
    if (rnd_bit) begin
      if (rnd_sig == 4'hF) begin
        if (rnd_exp != 3'd7) begin
          rnd_e = rnd_exp + 3'd1;
          rnd_f = 4'h8;
        end
      end else begin
        rnd_f = rnd_sig + 4'd1;
      end
    end
  end

  typedef struct {
    logic [11:0] d;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [2:0]  re;
    logic [3:0]  rs;
    logic        rb;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  logic [7:0] held = 8'd0;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  // Reference: value -> magnitude (clamped) -> scale by 2^k until it reaches
  // 1024 or k hits 7 -> take top bits -> round-half-up with carry/saturate.
  function automatic exp_t model(input logic [11:0] d);
    exp_t r;
    int v, m, k, sc, sig, rb, ex, t;
    v = d[11] ? int'(d) - 4096 : int'(d);
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    k = 0;
    while ((m * (2 ** k) < 1024) && (k < 7)) k++;
    sc  = m * (2 ** k);
    ex  = 7 - k;
    sig = sc / 128;
    rb  = (sc / 64) % 2;
    r.d  = d;
    r.s  = (v < 0);
    r.re = 3'(ex);
    r.rs = 4'(sig);
    r.rb = 1'(rb);
    t = sig + rb;
    if (t == 16) begin
      if (ex == 7) begin r.e = 3'd7; r.f = 4'hF; end
      else begin r.e = 3'(ex + 1); r.f = 4'h8; end
    end else begin
      r.e = 3'(ex);
      r.f = 4'(t);
    end
    r.lat = 3 + k;
    r.start_edge = 0;
    return r;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 8'd0;
      exp_q.delete();
    end else if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got s=%0d e=%0d f=%h, required no done", s, e, f);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if ({s, e, f} !== {x.s, x.e, x.f}) begin
          errors++;
          $display("FAIL result d=%h: got s=%0d e=%0d f=%h, required s=%0d e=%0d f=%h",
                   x.d, s, e, f, x.s, x.e, x.f);
        end
        checks++;
        if ({rnd_exp, rnd_sig, rnd_bit} !== {x.re, x.rs, x.rb}) begin
          errors++;
          $display("FAIL rnd_in d=%h: got exp=%0d sig=%h bit=%0d, required exp=%0d sig=%h bit=%0d",
                   x.d, rnd_exp, rnd_sig, rnd_bit, x.re, x.rs, x.rb);
        end
        checks++;
        if (edge_cnt - x.start_edge != x.lat) begin
          errors++;
          $display("FAIL latency d=%h: got %0d edges, required %0d", x.d, edge_cnt - x.start_edge, x.lat);
        end
      end
      held = {s, e, f};
    end else begin
      checks++;
      if ({s, e, f} !== held) begin
        errors++;
        $display("FAIL hold: got %h, required %h", {s, e, f}, held);
      end
    end
  end

  task automatic issue(input logic [11:0] d);
    exp_t x;
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0d, required 0", busy);
    end
    x = model(d);
    x.start_edge = edge_cnt + 1;
    exp_q.push_back(x);
    d_in  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, s, e, f} !== 10'd0) begin
      errors++;
      $display("FAIL %s: got busy=%0d done=%0d s=%0d e=%0d f=%h, required all 0",
               name, busy, done, s, e, f);
    end
  endtask

  initial begin
    logic [11:0] dir_tab [6];
    int guard;
    dir_tab = '{12'h000, 12'h07D, 12'h800, 12'hFFF, 12'h400, 12'h001};
    rst_n = 1'b0;
    start = 1'b0;
    d_in  = 12'd0;
    #1;
    check_zero("reset_state");
    #20;
    @(negedge clk);
    #2 rst_n = 1'b1;

    foreach (dir_tab[i]) issue(dir_tab[i]);
    repeat (40) issue(12'($urandom));

    // start toggled while converting must not queue a second conversion
    issue(12'h001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
    end
    start = 1'b0;

    // reset in the middle of NORM: immediate clear, no done
    issue(12'h07D);
    issue(12'h001);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(12'h400);
    repeat (40) issue(12'($urandom));

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (15) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
